// File: rtl/i2c_config_sequencer.sv
// Walks a register table and hands each {DEV_ADDR, reg, value} word to an I2C master,
// retrying NACKed entries a bounded number of times before aborting.
module i2c_config_sequencer #(
    parameter int          NUM_REGS    = 10,
    parameter logic [7:0]  DEV_ADDR    = 8'h34,
    parameter int          MAX_RETRIES = 3,
    parameter int          GAP_CYCLES  = 16,
    parameter int          AUTO_START  = 1,
    localparam int         IDX_W       = $clog2(NUM_REGS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_addr,
    input  logic [15:0]      tbl_data,
    output logic             xfer_start,
    output logic [23:0]      xfer_data,
    input  logic             xfer_end,
    input  logic             xfer_ack_n,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index,
    output logic [2:0]       dbg_state_o
);

    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        XFER  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             xfer_start_q, xfer_start_d;
    logic [23:0]      xfer_data_q, xfer_data_d;
    logic [IDX_W-1:0] err_index_q, err_index_d;
    // High only on the first cycle after reset release when AUTO_START is set.
    logic             auto_q, auto_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            index_q      <= '0;
            retry_q      <= '0;
            gap_q        <= '0;
            xfer_start_q <= 1'b0;
            xfer_data_q  <= '0;
            err_index_q  <= '0;
            auto_q       <= (AUTO_START != 0);
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            retry_q      <= retry_d;
            gap_q        <= gap_d;
            xfer_start_q <= xfer_start_d;
            xfer_data_q  <= xfer_data_d;
            err_index_q  <= err_index_d;
            auto_q       <= auto_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        retry_d      = retry_q;
        gap_d        = gap_q;
        xfer_start_d = xfer_start_q;
        xfer_data_d  = xfer_data_q;
        err_index_d  = err_index_q;
        auto_d       = 1'b0;
        case (state_q)
            IDLE, DONE, FAIL: begin
                // start is only honoured here, so a pulse while busy is dropped.
                if (start || (state_q == IDLE && auto_q)) begin
                    index_d = '0;
                    retry_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                xfer_data_d  = {DEV_ADDR, tbl_data};
                xfer_start_d = 1'b1;
                state_d      = XFER;
            end
            XFER: begin
                if (xfer_end) begin
                    xfer_start_d = 1'b0;
                    gap_d        = '0;
                    if (!xfer_ack_n) begin
                        if (index_q != IDX_W'(NUM_REGS)) index_d = index_q + 1'b1;
                        retry_d = '0;
                        state_d = GAP;
                    end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = GAP;
                    end else begin
                        err_index_d = index_q;
                        state_d     = FAIL;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = (index_q == IDX_W'(NUM_REGS)) ? DONE : FETCH;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tbl_addr    = index_q;
    assign xfer_start  = xfer_start_q;
    assign xfer_data   = xfer_data_q;
    assign err_index   = err_index_q;
    assign busy        = (state_q == FETCH) || (state_q == LOAD) ||
                         (state_q == XFER)  || (state_q == GAP);
    assign done        = (state_q == DONE);
    assign error       = (state_q == FAIL);
    assign dbg_state_o = state_q;

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 10, number of table entries sent per sequence (1..255).
REQ-002 SHALL have parameter DEV_ADDR, default 8'h34, 8-bit I2C write address sent as the first byte.
REQ-003 SHALL have parameter MAX_RETRIES, default 3, extra attempts allowed after a NACK (0 = no retry).
REQ-004 SHALL have parameter GAP_CYCLES, default 16, idle cycles between transfers (>=1).
REQ-005 SHALL have parameter AUTO_START, default 1, 1 = run the sequence once after reset without a start pulse.
REQ-006 SHALL derive IDX_W = clog2(NUM_REGS+1).
REQ-007 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port start  input  1  single-cycle request to run or re-run the sequence.
REQ-010 SHALL have port tbl_addr  output  IDX_W  table read index.
REQ-011 SHALL have port tbl_data  input  16  table word {reg_addr[6:0], value[8:0]}; valid exactly 1 cycle after tbl_addr.
REQ-012 SHALL have port xfer_start  output  1  request to the I2C master.
REQ-013 SHALL have port xfer_data  output  24  {DEV_ADDR, tbl_data}.
REQ-014 SHALL have port xfer_end  input  1  master finished the current transfer.
REQ-015 SHALL have port xfer_ack_n  input  1  sampled with xfer_end; 1 = NACK received.
REQ-016 SHALL have ports busy, done and error, each output 1: sequence running, sequence completed, sequence aborted.
REQ-017 SHALL have port err_index  output  IDX_W  table index that exhausted its retries.

Function
REQ-018 SHALL use states IDLE, FETCH, LOAD, XFER, GAP, DONE, FAIL.
REQ-019 IDLE: on start, or on the first cycle after reset when AUTO_START=1, SHALL clear index, retry count, done and error, then go to FETCH.
REQ-020 FETCH: SHALL drive tbl_addr=index for one cycle, then go to LOAD.
REQ-021 LOAD: SHALL register xfer_data={DEV_ADDR,tbl_data}, set xfer_start=1 and go to XFER; xfer_start SHALL rise 3 cycles after start is sampled.
REQ-022 XFER: SHALL hold xfer_start and xfer_data stable until xfer_end=1, then clear xfer_start on that edge.
REQ-023 On xfer_end with ACK (xfer_ack_n=0): SHALL increment index, clear the retry count and go to GAP.
REQ-024 On xfer_end with NACK and retry count < MAX_RETRIES: SHALL increment the retry count, keep the index and go to GAP.
REQ-025 On xfer_end with NACK and retry count = MAX_RETRIES: SHALL set error=1, set err_index=index and go to FAIL.
REQ-026 GAP: SHALL stay exactly GAP_CYCLES cycles, then go to DONE if index=NUM_REGS, else to FETCH.
REQ-027 DONE: SHALL hold done=1; FAIL SHALL hold error=1; in both states start SHALL restart as in REQ-019.
REQ-028 busy SHALL be 1 in FETCH, LOAD, XFER and GAP, and 0 otherwise.
REQ-029 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 Index and retry counters SHALL NOT wrap: index stops at NUM_REGS and retries stop at MAX_RETRIES.
REQ-031 Total attempts per entry SHALL be at most MAX_RETRIES+1.
REQ-032 xfer_end outside XFER SHALL be ignored.

Reset
REQ-033 rst_n low SHALL force IDLE, index=0, retries=0, xfer_start=0, xfer_data=0, tbl_addr=0, busy=0, done=0, error=0 and err_index=0, independent of clk.
REQ-034 Reset during XFER SHALL drop xfer_start immediately with no further transfers; with AUTO_START=1 the sequence SHALL restart from index 0 after reset release.

Verification
REQ-035 Defaults, master always ACKs -> exactly 10 transfers in table order, xfer_data[23:16]=8'h34 on each, >=16 idle cycles between xfer_end and the next xfer_start, then done=1, busy=0, error=0.
REQ-036 NACK once on index 4 -> index 4 sent twice, 11 transfers total, done=1, error=0.
REQ-037 NACK always on index 2, MAX_RETRIES=3 -> 4 attempts at index 2, no index-3 transfer, error=1, err_index=2, done=0.
REQ-038 AUTO_START=0 -> no xfer_start until a start pulse; xfer_start rises 3 cycles after start; start pulsed mid-sequence has no effect.
REQ-039 start in DONE or in FAIL -> done and error cleared, full sequence replayed from index 0.
REQ-040 rst_n asserted mid-XFER -> xfer_start=0 asynchronously, all outputs at reset values, sequence restarts from index 0 on release.
